// File: rtl/hit_timestamper.sv
// Edge timestamper: tags rise/fall pulses with a free-running coarse counter,
// inserts rollover markers on counter wrap, and buffers words in a FWFT FIFO.
module hit_timestamper #(
  parameter int unsigned CNT_W = 16,
  parameter int unsigned DEPTH = 8
) (
  input  logic                     iClk,
  input  logic                     iRst,
  input  logic                     iRise,
  input  logic                     iFall,
  output logic [CNT_W+1:0]         oData,
  output logic                     oValid,
  input  logic                     iReady,
  output logic [$clog2(DEPTH):0]   oCount,
  output logic                     oOverflow
);

  localparam int unsigned AW = $clog2(DEPTH);
  localparam logic [AW:0] FULL_CNT = (AW+1)'(DEPTH);

  typedef logic [CNT_W+1:0] word_t;

  logic [CNT_W-1:0] cnt_q;
  logic             wrap_q;
  logic             pend_q, pend_d;
  logic             ovf_q, ovf_d;
  logic [AW-1:0]    wr_q, rd_q;
  logic [AW:0]      count_q, count_d;
  word_t            mem_q [DEPTH];

  logic  full, push, pop, edge_w;
  word_t wdata;

  // wrap_q marks the cycle the counter reads 0 because it wrapped, not because
  // it was just reset, so a marker is never emitted right after reset.
  always_comb begin
    full    = (count_q == FULL_CNT);
    pop     = (count_q != '0) && iReady;
    edge_w  = iRise | iFall;
    push    = 1'b0;
    wdata   = '0;
    pend_d  = pend_q;
    ovf_d   = ovf_q;
    if (edge_w) begin
      wdata = {iFall, iRise, cnt_q};
      if (full) ovf_d = 1'b1;
      else      push  = 1'b1;
      if (wrap_q) begin
        if (pend_q) ovf_d = 1'b1;
        pend_d = 1'b1;
      end
    end else if (pend_q || wrap_q) begin
      if (pend_q && wrap_q) ovf_d = 1'b1;
      if (full) begin
        pend_d = 1'b1;
      end else begin
        push   = 1'b1;
        pend_d = 1'b0;
      end
    end
    count_d = count_q + (AW+1)'(push) - (AW+1)'(pop);
  end

  always_ff @(posedge iClk) begin
    if (iRst) begin
      cnt_q   <= '0;
      wrap_q  <= 1'b0;
      pend_q  <= 1'b0;
      ovf_q   <= 1'b0;
      wr_q    <= '0;
      rd_q    <= '0;
      count_q <= '0;
    end else begin
      cnt_q   <= cnt_q + CNT_W'(1);
      wrap_q  <= &cnt_q;
      pend_q  <= pend_d;
      ovf_q   <= ovf_d;
      wr_q    <= wr_q + AW'(push);
      rd_q    <= rd_q + AW'(pop);
      count_q <= count_d;
    end
  end

  always_ff @(posedge iClk) begin
    if (!iRst && push) mem_q[wr_q] <= wdata;
  end

  assign oData     = mem_q[rd_q];
  assign oValid    = (count_q != '0);
  assign oCount    = count_q;
  assign oOverflow = ovf_q;

endmodule

// File: tb/tb_hit_timestamper.sv
// Self-checking bench for hit_timestamper (CNT_W=8, DEPTH=4) against a
// queue-based reference model of the event stream.
module tb_hit_timestamper;

  localparam int unsigned CW = 8;
  localparam int unsigned DP = 4;

  logic          iClk = 1'b0;
  logic          iRst, iRise, iFall, iReady;
  logic [CW+1:0] oData;
  logic          oValid, oOverflow;
  logic [2:0]    oCount;

  hit_timestamper #(.CNT_W(CW), .DEPTH(DP)) dut (
    .iClk(iClk), .iRst(iRst), .iRise(iRise), .iFall(iFall),
    .oData(oData), .oValid(oValid), .iReady(iReady),
    .oCount(oCount), .oOverflow(oOverflow)
  );

  always #5 iClk = ~iClk;

  int unsigned n_assert = 0;
  int unsigned n_fail   = 0;

  // Reference model state: counter value of the upcoming cycle, whether that
  // cycle is the first after reset, stored words, pending marker, sticky flag.
  logic [CW+1:0] mq[$];
  int unsigned   m_cnt;
  bit            m_first;
  bit            m_pend;
  bit            m_ovf;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic check_outputs();
    check("count", 32'(oCount), 32'(mq.size()));
    check("valid", 32'(oValid), 32'(mq.size() != 0));
    check("overflow", 32'(oOverflow), 32'(m_ovf));
    if (mq.size() != 0) check("data", 32'(oData), 32'(mq[0]));
  endtask

  task automatic tick(input bit rise, input bit fall, input bit ready);
    bit full, roll, want;
    iRise = rise; iFall = fall; iReady = ready; iRst = 1'b0;
    full = (mq.size() == DP);
    roll = (m_cnt == 0) && !m_first;
    if (mq.size() != 0 && ready) void'(mq.pop_front());
    if (rise || fall) begin
      if (full) m_ovf = 1'b1;
      else      mq.push_back({fall, rise, CW'(m_cnt)});
      if (roll) begin
        if (m_pend) m_ovf = 1'b1;
        m_pend = 1'b1;
      end
    end else begin
      want = m_pend || roll;
      if (m_pend && roll) m_ovf = 1'b1;
      if (want) begin
        if (full) m_pend = 1'b1;
        else begin
          mq.push_back('0);
          m_pend = 1'b0;
        end
      end
    end
    m_cnt   = (m_cnt + 1) % 256;
    m_first = 1'b0;
    @(posedge iClk);
    #1;
    check_outputs();
  endtask

  task automatic do_reset(input bit rise, input bit fall, input bit ready);
    iRst = 1'b1; iRise = rise; iFall = fall; iReady = ready;
    mq.delete();
    m_cnt = 0; m_first = 1'b1; m_pend = 1'b0; m_ovf = 1'b0;
    @(posedge iClk);
    #1;
    check_outputs();
  endtask

  task automatic idle_until(input int unsigned target, input bit ready);
    for (int k = 0; k < 300 && m_cnt != target; k++) tick(1'b0, 1'b0, ready);
  endtask

  int unsigned markers;

  initial begin
    iRst = 1'b1; iRise = 1'b0; iFall = 1'b0; iReady = 1'b0;
    do_reset(1'b1, 1'b1, 1'b1);

    // Rise at counter 5, consumer ready
    idle_until(5, 1'b1);
    tick(1'b1, 1'b0, 1'b1);
    check("rise5_word", 32'(oData), 32'h105);
    check("rise5_valid", 32'(oValid), 32'd1);
    tick(1'b0, 1'b0, 1'b1);
    check("rise5_popped", 32'(oCount), 32'd0);

    // Rise and fall together at counter 20
    idle_until(20, 1'b0);
    tick(1'b1, 1'b1, 1'b0);
    check("both20_word", 32'(oData), 32'h314);
    check("both20_count", 32'(oCount), 32'd1);

    // Exactly one rollover marker in any 256-cycle window with no edges
    do_reset(1'b0, 1'b0, 1'b1);
    for (int k = 0; k < 10; k++) tick(1'b0, 1'b0, 1'b1);
    markers = 0;
    for (int k = 0; k < 256; k++) begin
      tick(1'b0, 1'b0, 1'b1);
      if (oValid && oData == '0) markers++;
    end
    check("rollover_once", markers, 32'd1);

    // Five rises into a depth-4 FIFO with the consumer stalled
    do_reset(1'b0, 1'b0, 1'b0);
    for (int e = 10; e <= 18; e += 2) begin
      idle_until(e, 1'b0);
      tick(1'b1, 1'b0, 1'b0);
    end
    check("full_count", 32'(oCount), 32'd4);
    check("full_ovf", 32'(oOverflow), 32'd1);
    check("full_head", 32'(oData), 32'h10A);
    // Full at start of cycle: edge rejected even though a pop happens
    tick(1'b1, 1'b0, 1'b1);
    check("full_pop_reject", 32'(oCount), 32'd3);
    check("order_2", 32'(oData), 32'h10C);
    tick(1'b0, 1'b0, 1'b1);
    check("order_3", 32'(oData), 32'h10E);
    tick(1'b0, 1'b0, 1'b1);
    check("order_4", 32'(oData), 32'h110);

    // Fall coinciding with counter wrap: edge first, marker next cycle
    do_reset(1'b0, 1'b0, 1'b0);
    idle_until(255, 1'b0);
    tick(1'b0, 1'b0, 1'b0);
    idle_until(0, 1'b0);
    tick(1'b0, 1'b1, 1'b0);
    check("wrap_fall_word", 32'(oData), 32'h200);
    tick(1'b0, 1'b0, 1'b0);
    check("wrap_marker_count", 32'(oCount), 32'd2);
    tick(1'b0, 1'b0, 1'b1);
    check("wrap_marker_word", 32'(oData), 32'h000);

    // Reset with stored words and overflow set, concurrent edges ignored
    do_reset(1'b0, 1'b0, 1'b0);
    for (int k = 0; k < 5; k++) tick(1'b1, 1'b0, 1'b0);
    tick(1'b0, 1'b0, 1'b1);
    check("pre_reset_count", 32'(oCount), 32'd3);
    do_reset(1'b1, 1'b0, 1'b1);
    check("post_reset_count", 32'(oCount), 32'd0);
    check("post_reset_valid", 32'(oValid), 32'd0);
    check("post_reset_ovf", 32'(oOverflow), 32'd0);
    tick(1'b1, 1'b0, 1'b0);
    check("post_reset_cnt0", 32'(oData), 32'h100);

    // Full FIFO across two wraps: pending marker, then its overflow
    do_reset(1'b0, 1'b0, 1'b0);
    for (int k = 0; k < 4; k++) tick(1'b0, 1'b1, 1'b0);
    for (int k = 0; k < 600; k++) tick(1'b0, 1'b0, 1'b0);
    check("pend_ovf", 32'(oOverflow), 32'd1);
    for (int k = 0; k < 8; k++) tick(1'b0, 1'b0, 1'b1);

    // Randomized traffic with occasional resets
    do_reset(1'b0, 1'b0, 1'b0);
    for (int k = 0; k < 3000; k++) begin
      if ($urandom_range(0, 499) == 0)
        do_reset(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
      else
        tick(1'($urandom_range(0, 3) == 0), 1'($urandom_range(0, 3) == 0),
             1'(((k / 200) % 2 == 0) ? ($urandom_range(0, 3) != 0) : ($urandom_range(0, 3) == 0)));
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
